cdc_handshake_tx: RTL and testbench
===================================

Name: cdc_handshake_tx

Overview:
- Source-side transmitter of a 4-phase REQ/ACK clock-domain-crossing handshake.
- Accepts a word from local logic over a valid/ready interface and drives it onto a bus held stable for the whole transaction.
- Raises REQ and waits for the far domain's ACK. ACK arrives asynchronously and passes through an internal multi-flop synchronizer.
- Pairs with the destination-side bit synchronizer that samples REQ in the receiving domain.

Parameters:
- BUS_WIDTH, 8: width of the data word carried across the crossing.
- NUM_STAGES, 2: flop stages in the internal ACK synchronizer; legal values 2 and above.
- TIMEOUT_CYCLES, 255: maximum cycles spent in either wait state before abort; 0 disables the timeout.

Ports:
- CLK  input  1  source-domain clock; all logic is rising-edge.
- RST  input  1  asynchronous, active-low reset.
- IN_DATA  input  BUS_WIDTH  word to transmit.
- IN_VALID  input  1  IN_DATA is valid.
- IN_READY  output  1  block can accept a word this cycle.
- TX_DATA  output  BUS_WIDTH  registered data bus to the far domain.
- TX_REQ  output  1  registered request to the far domain.
- ACK_ASYNC  input  1  acknowledge from the far domain; asynchronous to CLK.
- DONE  output  1  one-cycle pulse: transaction completed normally.
- ERR  output  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset (RST low, asynchronous):
  - State IDLE.
  - TX_DATA=0, TX_REQ=0, DONE=0, ERR=0.
  - IN_READY=1 once RST is released.
  - Every synchronizer stage and the timeout counter cleared.
- ACK synchronizer:
  - ACK_ASYNC passes through NUM_STAGES flops to give ack_s.
  - A change on ACK_ASYNC is visible on ack_s after exactly NUM_STAGES rising edges.
  - Only ack_s is used by the FSM.
- IN_READY is combinational and equals (state==IDLE).
- IDLE:
  - On an edge with IN_VALID=1 and IN_READY=1: TX_DATA<=IN_DATA, TX_REQ<=1, go to WAIT_ACK_HI, counter<=0.
  - Otherwise TX_DATA and TX_REQ hold.
- WAIT_ACK_HI:
  - If ack_s=1: TX_REQ<=0, go to WAIT_ACK_LO, counter<=0.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: TX_REQ<=0, ERR<=1 for one cycle, set internal abort flag, go to WAIT_ACK_LO, counter<=0.
  - Otherwise counter increments.
- WAIT_ACK_LO:
  - If ack_s=0: go to IDLE. DONE<=1 for one cycle, unless the abort flag is set, in which case no DONE is issued and the flag is cleared.
  - Else if timeout expires (same rule as above): ERR pulse, go to IDLE, abort flag cleared.
  - Otherwise counter increments.
- Data stability: TX_DATA changes only on acceptance in IDLE and is constant while TX_REQ=1 and throughout WAIT_ACK_LO.
- Back-to-back: a new word may be accepted in the same cycle DONE is high, because state is already IDLE.
- Nominal latency:
  - Acceptance edge to TX_REQ=1: 1 edge.
  - ACK_ASYNC rise to TX_REQ fall: NUM_STAGES+1 edges.
  - ACK_ASYNC fall to DONE: NUM_STAGES+1 edges.
- Early/stale ACK: ACK already high in IDLE has no effect. After acceptance, if ack_s is high, the FSM proceeds to WAIT_ACK_LO on the next edge.
- DONE and ERR are never high in the same cycle.
- The counter width must hold TIMEOUT_CYCLES without overflow.
- RST asserted mid-transaction: TX_REQ drops immediately, state returns to IDLE, no DONE or ERR pulse.

Test Plan:
- Reset check: with RST low, TX_REQ=0, TX_DATA=0x00, DONE=0, ERR=0. After RST goes high, IN_READY=1.
- Nominal transfer (NUM_STAGES=2): send IN_DATA=0xA5 with IN_VALID for 1 cycle.
  - TX_REQ=1 and TX_DATA=0xA5 after the next edge; IN_READY=0.
  - Raise ACK_ASYNC: TX_REQ falls on the 3rd edge.
  - Drop ACK_ASYNC: DONE pulses 1 cycle on the 3rd edge.
  - TX_DATA stays 0xA5 throughout.
- Back-to-back: hold IN_VALID=1 with 0x11 then 0x22. 0x22 is accepted in the DONE cycle of 0x11, and TX_REQ rises on the following edge.
- Timeout (TIMEOUT_CYCLES=8): never assert ACK. ERR pulses and TX_REQ falls 8 cycles after TX_REQ rose, IN_READY returns to 1, and DONE is never asserted.
- Late ACK after abort: same setup, then ACK_ASYNC pulses high then low. The FSM waits for ack_s low, returns to IDLE, and emits no DONE.
- Reset mid-operation: pull RST low while in WAIT_ACK_HI. TX_REQ goes to 0 without waiting for an edge, and after release a fresh 0x3C transfer completes normally.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
//   Source side of a 4-phase REQ/ACK clock-domain crossing. A word accepted
//   over a valid/ready interface is parked on TX_DATA and held stable while
//   TX_REQ is raised and the far domain's ACK is awaited (rise, then fall).
//   ACK_ASYNC is resynchronised through NUM_STAGES flops before use.
//   A per-wait-state timeout aborts a stuck transaction with an ERR pulse.
//
// Ports
//   CLK        source-domain clock, rising edge
//   RST        asynchronous active-low reset
//   IN_DATA    word to transmit
//   IN_VALID   IN_DATA is valid
//   IN_READY   block is idle and accepts a word this cycle (combinational)
//   TX_DATA    registered data bus to the far domain
//   TX_REQ     registered request to the far domain
//   ACK_ASYNC  acknowledge from the far domain, asynchronous to CLK
//   DONE       one-cycle pulse: transaction completed normally
//   ERR        one-cycle pulse: transaction aborted on timeout
//
// NUM_STAGES must be 2 or more; TIMEOUT_CYCLES of 0 disables the timeout.

module cdc_handshake_tx #(
  parameter int unsigned BUS_WIDTH      = 8,
  parameter int unsigned NUM_STAGES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] IN_DATA,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [BUS_WIDTH-1:0] TX_DATA,
  output logic                 TX_REQ,
  input  logic                 ACK_ASYNC,
  output logic                 DONE,
  output logic                 ERR
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_ACK_HI = 2'd1,
    S_WAIT_ACK_LO = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [BUS_WIDTH-1:0]  r_data,  w_data_nxt;
  logic                  r_req,   w_req_nxt;
  logic                  r_done,  w_done_nxt;
  logic                  r_err,   w_err_nxt;
  logic                  r_abort, w_abort_nxt;
  logic [CNT_W-1:0]      r_cnt,   w_cnt_nxt;
  logic [NUM_STAGES-1:0] r_ack_sync;
  logic                  w_ack_s;
  logic                  w_timeout;

  // ACK resynchroniser: stage 0 samples the asynchronous input, the last
  // stage is the only copy the FSM ever looks at.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[NUM_STAGES-2:0], ACK_ASYNC};
    end
  end

  assign w_ack_s   = r_ack_sync[NUM_STAGES-1];
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST_C);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_req   <= w_req_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_abort <= w_abort_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_req_nxt   = r_req;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_abort_nxt = r_abort;
    w_cnt_nxt   = r_cnt + CNT_W'(1);

    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (IN_VALID) begin
          w_data_nxt  = IN_DATA;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_WAIT_ACK_HI;
        end
      end

      S_WAIT_ACK_HI: begin
        // ACK wins over a timeout expiring on the same edge.
        if (w_ack_s) begin
          w_req_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_ACK_LO;
        end else if (w_timeout) begin
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_abort_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_ACK_LO;
        end
      end

      S_WAIT_ACK_LO: begin
        // After an abort we still wait for ACK to be low so a late ACK from
        // the far side cannot leak into the next transaction; no DONE then.
        if (!w_ack_s) begin
          w_done_nxt  = !r_abort;
          w_abort_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_abort_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_req_nxt   = 1'b0;
        w_abort_nxt = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign IN_READY = (r_state == S_IDLE);
  assign TX_DATA  = r_data;
  assign TX_REQ   = r_req;
  assign DONE     = r_done;
  assign ERR      = r_err;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx (NUM_STAGES=2, TIMEOUT_CYCLES=8). Expected
// waveforms are derived from edge counts: with inputs changed just after
// edge k, ACK becomes visible to the FSM at edge k+NUM_STAGES+1, and a wait
// state entered at edge t times out at edge t+TIMEOUT_CYCLES.
module tb_cdc_handshake_tx;

  localparam int NS = 2;
  localparam int TO = 8;

  logic       CLK;
  logic       RST;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] TX_DATA;
  logic       TX_REQ;
  logic       ACK_ASYNC;
  logic       DONE;
  logic       ERR;

  int n_checks = 0;
  int n_fail   = 0;

  cdc_handshake_tx #(
    .BUS_WIDTH      (8),
    .NUM_STAGES     (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .TX_DATA   (TX_DATA),
    .TX_REQ    (TX_REQ),
    .ACK_ASYNC (ACK_ASYNC),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    RST = 1'b0; IN_DATA = 8'h00; IN_VALID = 1'b0; ACK_ASYNC = 1'b0;
    #2;
    n_checks++; if (TX_REQ !== 1'b0)   begin n_fail++; $display("FAIL reset_req got %b exp 0", TX_REQ); end
    n_checks++; if (TX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", TX_DATA); end
    n_checks++; if (DONE !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b exp 0", DONE); end
    n_checks++; if (ERR !== 1'b0)      begin n_fail++; $display("FAIL reset_err got %b exp 0", ERR); end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", IN_READY); end
    n_checks++; if (TX_REQ !== 1'b0)   begin n_fail++; $display("FAIL reset_req_after got %b exp 0", TX_REQ); end
  endtask

  // One transaction. h: edge after which ACK rises (h>5 means ACK never
  // rises and the first wait times out). g: cycles ACK stays high after
  // TX_REQ falls (g>5 means the second wait times out).
  task automatic test_transfer(input logic [7:0] d, input int h, input int g);
    int  f, dn, er, e, kmax;
    bit  ab;
    logic exp_req, exp_done, exp_err, exp_rdy;
    ab = (h > TO - NS - 1);
    if (ab) begin
      f = TO; er = TO; e = TO + 1; dn = -1; kmax = e + 1;
    end else begin
      f = h + NS + 1;
      if (g <= TO - NS - 1) begin
        dn = f + g + NS + 1; er = -1; e = dn;
      end else begin
        dn = -1; er = f + TO; e = f + TO;
      end
      kmax = ((e > f + g + NS + 1) ? e : f + g + NS + 1) + 1;
    end
    @(negedge CLK);
    IN_DATA = d; IN_VALID = 1'b1;
    for (int k = 0; k <= kmax; k++) begin
      @(posedge CLK); #1;
      exp_req  = (k < f);
      exp_done = (k == dn);
      exp_err  = (k == er);
      exp_rdy  = (k >= e);
      n_checks++; if (TX_REQ !== exp_req)   begin n_fail++; $display("FAIL xfer_req k=%0d h=%0d g=%0d got %b exp %b", k, h, g, TX_REQ, exp_req); end
      n_checks++; if (DONE !== exp_done)    begin n_fail++; $display("FAIL xfer_done k=%0d h=%0d g=%0d got %b exp %b", k, h, g, DONE, exp_done); end
      n_checks++; if (ERR !== exp_err)      begin n_fail++; $display("FAIL xfer_err k=%0d h=%0d g=%0d got %b exp %b", k, h, g, ERR, exp_err); end
      n_checks++; if (IN_READY !== exp_rdy) begin n_fail++; $display("FAIL xfer_ready k=%0d h=%0d g=%0d got %b exp %b", k, h, g, IN_READY, exp_rdy); end
      n_checks++; if (TX_DATA !== d)        begin n_fail++; $display("FAIL xfer_data k=%0d got %h exp %h", k, TX_DATA, d); end
      @(negedge CLK);
      if (k == 0) begin IN_VALID = 1'b0; IN_DATA = 8'($urandom); end
      if (!ab && k == h)     ACK_ASYNC = 1'b1;
      if (!ab && k == f + g) ACK_ASYNC = 1'b0;
    end
  endtask

  task automatic test_nominal();
    test_transfer(8'hA5, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic       exp_req, exp_done, exp_rdy;
    logic [7:0] exp_data;
    @(negedge CLK);
    IN_DATA = 8'h11; IN_VALID = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(posedge CLK); #1;
      exp_req  = (k < 3) || (k >= 7 && k < 10);
      exp_done = (k == 6) || (k == 13);
      exp_rdy  = (k == 6) || (k >= 13);
      exp_data = (k < 7) ? 8'h11 : 8'h22;
      n_checks++; if (TX_REQ !== exp_req)    begin n_fail++; $display("FAIL b2b_req k=%0d got %b exp %b", k, TX_REQ, exp_req); end
      n_checks++; if (DONE !== exp_done)     begin n_fail++; $display("FAIL b2b_done k=%0d got %b exp %b", k, DONE, exp_done); end
      n_checks++; if (ERR !== 1'b0)          begin n_fail++; $display("FAIL b2b_err k=%0d got %b exp 0", k, ERR); end
      n_checks++; if (IN_READY !== exp_rdy)  begin n_fail++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, IN_READY, exp_rdy); end
      n_checks++; if (TX_DATA !== exp_data)  begin n_fail++; $display("FAIL b2b_data k=%0d got %h exp %h", k, TX_DATA, exp_data); end
      @(negedge CLK);
      if (k == 0)  begin IN_DATA = 8'h22; ACK_ASYNC = 1'b1; end
      if (k == 3)  ACK_ASYNC = 1'b0;
      if (k == 7)  begin IN_VALID = 1'b0; ACK_ASYNC = 1'b1; end
      if (k == 10) ACK_ASYNC = 1'b0;
    end
  endtask

  task automatic test_timeout();
    test_transfer(8'h5A, 9, 0);
  endtask

  // ACK arrives too late: first wait times out at edge 8 while ack_s is
  // about to rise; the FSM then holds until ack_s falls (edge 12), no DONE.
  task automatic test_late_ack();
    logic exp_req, exp_err, exp_rdy;
    @(negedge CLK);
    IN_DATA = 8'hC3; IN_VALID = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(posedge CLK); #1;
      exp_req = (k < TO);
      exp_err = (k == TO);
      exp_rdy = (k >= 9 + NS + 1);
      n_checks++; if (TX_REQ !== exp_req)   begin n_fail++; $display("FAIL late_req k=%0d got %b exp %b", k, TX_REQ, exp_req); end
      n_checks++; if (ERR !== exp_err)      begin n_fail++; $display("FAIL late_err k=%0d got %b exp %b", k, ERR, exp_err); end
      n_checks++; if (DONE !== 1'b0)        begin n_fail++; $display("FAIL late_done k=%0d got %b exp 0", k, DONE); end
      n_checks++; if (IN_READY !== exp_rdy) begin n_fail++; $display("FAIL late_ready k=%0d got %b exp %b", k, IN_READY, exp_rdy); end
      n_checks++; if (TX_DATA !== 8'hC3)    begin n_fail++; $display("FAIL late_data k=%0d got %h exp c3", k, TX_DATA); end
      @(negedge CLK);
      if (k == 0) IN_VALID = 1'b0;
      if (k == 6) ACK_ASYNC = 1'b1;
      if (k == 9) ACK_ASYNC = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    IN_DATA = 8'h77; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    n_checks++; if (TX_REQ !== 1'b1)   begin n_fail++; $display("FAIL rmid_req_before got %b exp 1", TX_REQ); end
    RST = 1'b0;
    #1;
    n_checks++; if (TX_REQ !== 1'b0)   begin n_fail++; $display("FAIL rmid_req got %b exp 0", TX_REQ); end
    n_checks++; if (TX_DATA !== 8'h00) begin n_fail++; $display("FAIL rmid_data got %h exp 00", TX_DATA); end
    n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b exp 1", IN_READY); end
    n_checks++; if (DONE !== 1'b0 || ERR !== 1'b0) begin n_fail++; $display("FAIL rmid_pulse got done=%b err=%b exp 0 0", DONE, ERR); end
    @(negedge CLK);
    RST = 1'b1;
    test_transfer(8'h3C, 1, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      test_transfer(8'($urandom), int'($urandom_range(0, 9)), int'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_timeout();
    test_late_ack();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
